tile_sched: RTL and testbench
=============================

# tile_sched

Tile-loop scheduler between the UART/CSR command front end and the systolic-array datapath in `accel_top`. It takes a GEMM problem size (M×N×K) and walks it in TM×TN×TK tiles. For each tile it issues one start to the datapath with tile indices and valid edge lengths, then waits for the datapath's completion. It reports per-output-tile and whole-job completion. K is the innermost loop, so the datapath can accumulate partial sums across K tiles.

## Interface
- `TM`, 8, tile rows (M direction)
- `TN`, 8, tile columns (N direction)
- `TK`, 8, tile depth (K direction)
- `DIM_W`, 16, width of problem dimensions and tile indices
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle job request; sampled only in IDLE
- `abort`  in  1  synchronous job cancel
- `cfg_m`, `cfg_n`, `cfg_k`  in  DIM_W each  problem dimensions in elements; sampled on an accepted `start`
- `dp_ready`  in  1  datapath can accept a tile
- `dp_done`  in  1  one-cycle pulse: the issued tile has finished
- `tile_start`  out  1  one-cycle tile issue to the datapath
- `tile_m_idx`, `tile_n_idx`, `tile_k_idx`  out  DIM_W each  current tile indices
- `tile_m_len`, `tile_n_len`, `tile_k_len`  out  $clog2(T*+1) each  valid elements in the current tile
- `first_k`  out  1  current tile has k_idx==0; datapath clears its accumulator
- `last_k`  out  1  current tile is the last K tile; datapath writes C
- `busy`  out  1  job in progress
- `done_tile`  out  1  one-cycle pulse: an output (m,n) tile has completed
- `done`  out  1  one-cycle pulse: job complete
- `cfg_err`  out  1  one-cycle pulse: `start` was rejected because a dimension is 0

## Operation
- On an accepted `start`, latch the tile counts, each a ceiling division: MT=⌈cfg_m/TM⌉, NT=⌈cfg_n/TN⌉, KT=⌈cfg_k/TK⌉. Use DIM_W-bit arithmetic; cfg+T−1 must not overflow, so compute the ceiling as (cfg>>log2 T) + |remainder| when T is a power of 2, or widen by 1 bit otherwise.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE on `start` with all dimensions non-zero. All indices reset to 0.
- IDLE with `start` and any dimension 0: pulse `cfg_err` on the next cycle and stay in IDLE.
- ISSUE: assert `tile_start` combinationally in any cycle where `dp_ready`=1, then go to WAIT. While `dp_ready`=0, stay in ISSUE with `tile_start`=0.
- WAIT: on `dp_done`, advance the indices in this order: k++; on k wrap, k=0 and n++; on n wrap, n=0 and m++.
  - Not the final tile: go to ISSUE.
  - Final tile (m=MT−1, n=NT−1, k=KT−1): go to DONE.
- `done_tile` pulses the cycle after any `dp_done` received while `last_k`=1.
- DONE: `done`=1 for one cycle, `busy` stays 1, then go to IDLE.
- Edge lengths:
  - tile_m_len = min(TM, cfg_m − m_idx·TM); tile_n_len and tile_k_len follow the same rule.
  - All three are registered and updated together with the indices.
- Indices, lengths, `first_k` and `last_k` hold stable from ISSUE entry until the next `dp_done`.
- `dp_done` outside WAIT is ignored. `start` while not in IDLE is ignored; the latched configuration is unchanged.
- `abort` in ISSUE, WAIT or DONE: go to IDLE next cycle.
  - No `tile_start`, `done_tile` or `done` is produced after `abort` is sampled.
  - `abort` has priority over `dp_done` in the same cycle.
  - `abort` in IDLE has no effect.

## Timing
- Reset values: state IDLE; all outputs 0; indices, lengths and counts 0.
- Reset mid-job returns immediately to IDLE with no pulses.
- Job start: `start` at cycle 0 → `busy`=1 and state ISSUE at cycle 1 → `tile_start` at cycle 1 at the earliest.
- Tile turnaround: `dp_done` at cycle t → new indices and ISSUE at t+1 → next `tile_start` at t+1 at the earliest.
  - Back-to-back issue costs one bubble cycle (the WAIT cycle).
- Job end: final `dp_done` at cycle t → `done_tile`=1 and `done`=1 at t+1 → `busy`=0 at t+2.
- `cfg_err` is registered and pulses at cycle 1 after a rejected `start` at cycle 0.
- A job with MT·NT·KT tiles produces exactly:
  - MT·NT·KT `tile_start` pulses
  - MT·NT `done_tile` pulses
  - 1 `done` pulse

## Test plan
- Full tiles: TM=TN=TK=8, cfg=16/16/16, `dp_ready`=1, `dp_done` 3 cycles after each `tile_start`.
  - Exactly 8 `tile_start` pulses, with (m,n,k) in order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…(1,1,1).
  - 4 `done_tile` pulses, 1 `done` pulse, `busy`=0 two cycles after the last `dp_done`.
- Edge tiles: cfg=10/8/3.
  - 2 tiles, with tile_m_len 8 then 2, tile_n_len 8, tile_k_len 3.
  - `first_k`=`last_k`=1 on both tiles; 2 `done_tile` pulses.
- Zero dimension: `start` with cfg_k=0 → `cfg_err` pulses at cycle 1; `busy`, `tile_start` and `done` stay 0.
- Backpressure: hold `dp_ready`=0 for 5 cycles in ISSUE.
  - `tile_start` asserts in the first cycle `dp_ready`=1; indices and lengths stay unchanged throughout.
  - A stray `dp_done` during ISSUE is ignored.
- Abort: `abort` together with `dp_done` during WAIT of tile 2.
  - `busy`=0 the next cycle, and no `done_tile` or `done`.
  - A following `start` with cfg=8/8/8 runs exactly 1 tile from indices (0,0,0).
- Ignored start and reset mid-job:
  - A second `start` mid-job with different cfg leaves the tile count and lengths unchanged.
  - Asserting `rst_n`=0 mid-WAIT clears all outputs asynchronously; the next job behaves as a fresh one.

Source files
------------

// File: rtl/tile_sched.sv
// -----------------------------------------------------------------------------
// tile_sched
// Tile-loop scheduler. It takes a GEMM problem of M x N x K elements and walks
// it in TM x TN x TK tiles, with K innermost. For each tile it issues one
// start pulse to the systolic datapath and then waits for the datapath's
// completion pulse. It reports per-output-tile and whole-job completion.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, cfg_m/n/k                 job request and problem dimensions
//   abort                            synchronous job cancel
//   dp_ready, dp_done                datapath handshake
//   tile_start                       one-cycle tile issue (combinational on dp_ready)
//   tile_{m,n,k}_idx                 current tile indices
//   tile_{m,n,k}_len                 valid elements in the current tile
//   first_k, last_k                  accumulator clear / write-back hints
//   busy, done_tile, done, cfg_err   job status
// -----------------------------------------------------------------------------
module tile_sched #(
  parameter int unsigned TM    = 8,
  parameter int unsigned TN    = 8,
  parameter int unsigned TK    = 8,
  parameter int unsigned DIM_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIM_W-1:0]           cfg_m,
  input  logic [DIM_W-1:0]           cfg_n,
  input  logic [DIM_W-1:0]           cfg_k,
  input  logic                       dp_ready,
  input  logic                       dp_done,
  output logic                       tile_start,
  output logic [DIM_W-1:0]           tile_m_idx,
  output logic [DIM_W-1:0]           tile_n_idx,
  output logic [DIM_W-1:0]           tile_k_idx,
  output logic [$clog2(TM+1)-1:0]    tile_m_len,
  output logic [$clog2(TN+1)-1:0]    tile_n_len,
  output logic [$clog2(TK+1)-1:0]    tile_k_len,
  output logic                       first_k,
  output logic                       last_k,
  output logic                       busy,
  output logic                       done_tile,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int unsigned LM_W  = $clog2(TM + 1);
  localparam int unsigned LN_W  = $clog2(TN + 1);
  localparam int unsigned LK_W  = $clog2(TK + 1);
  localparam int unsigned TM_SH = $clog2(TM);
  localparam int unsigned TN_SH = $clog2(TN);
  localparam int unsigned TK_SH = $clog2(TK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Ceiling division that never overflows DIM_W: shift plus remainder-OR for
  // power-of-two tiles, a one-bit-wider add-and-divide otherwise.
  function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] v,
                                                input int unsigned     t,
                                                input int unsigned     sh);
    logic [DIM_W:0]   wide;
    logic [DIM_W-1:0] mask;
    wide = '0;
    mask = DIM_W'(t - 32'd1);
    if ((t & (t - 32'd1)) == 32'd0) begin
      ceil_div = (v >> sh) + {{(DIM_W-1){1'b0}}, |(v & mask)};
    end else begin
      wide     = ({1'b0, v} + (DIM_W+1)'(t - 32'd1)) / (DIM_W+1)'(t);
      ceil_div = wide[DIM_W-1:0];
    end
  endfunction

  // Edge length of a tile: the remaining elements, capped at the tile size.
  function automatic logic [DIM_W-1:0] clamp_len(input logic [DIM_W-1:0] rem,
                                                 input int unsigned     t);
    if (rem > DIM_W'(t)) begin
      clamp_len = DIM_W'(t);
    end else begin
      clamp_len = rem;
    end
  endfunction

  state_e           state_q, state_d;
  logic [DIM_W-1:0] mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
  logic [DIM_W-1:0] cfg_n_q, cfg_n_d, cfg_k_q, cfg_k_d;
  logic [DIM_W-1:0] m_idx_q, m_idx_d, n_idx_q, n_idx_d, k_idx_q, k_idx_d;
  // Elements remaining from the current index onward; lengths derive from these
  // so no index*T multiply is needed.
  logic [DIM_W-1:0] rem_m_q, rem_m_d, rem_n_q, rem_n_d, rem_k_q, rem_k_d;
  logic [LM_W-1:0]  m_len_q, m_len_d;
  logic [LN_W-1:0]  n_len_q, n_len_d;
  logic [LK_W-1:0]  k_len_q, k_len_d;
  logic             first_k_q, first_k_d, last_k_q, last_k_d;
  logic             done_tile_q, done_tile_d, cfg_err_q, cfg_err_d;
  logic             tile_start_s;
  logic             k_wrap_s, n_wrap_s, m_last_s, final_s;

  assign k_wrap_s = (k_idx_q == (kt_q - {{(DIM_W-1){1'b0}}, 1'b1}));
  assign n_wrap_s = (n_idx_q == (nt_q - {{(DIM_W-1){1'b0}}, 1'b1}));
  assign m_last_s = (m_idx_q == (mt_q - {{(DIM_W-1){1'b0}}, 1'b1}));
  assign final_s  = k_wrap_s & n_wrap_s & m_last_s;

  // Next-state, tile-walk and issue logic.
  always_comb begin
    state_d      = state_q;
    mt_d         = mt_q;
    nt_d         = nt_q;
    kt_d         = kt_q;
    cfg_n_d      = cfg_n_q;
    cfg_k_d      = cfg_k_q;
    m_idx_d      = m_idx_q;
    n_idx_d      = n_idx_q;
    k_idx_d      = k_idx_q;
    rem_m_d      = rem_m_q;
    rem_n_d      = rem_n_q;
    rem_k_d      = rem_k_q;
    first_k_d    = first_k_q;
    last_k_d     = last_k_q;
    done_tile_d  = 1'b0;
    cfg_err_d    = 1'b0;
    tile_start_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d   = S_ISSUE;
            mt_d      = ceil_div(cfg_m, TM, TM_SH);
            nt_d      = ceil_div(cfg_n, TN, TN_SH);
            kt_d      = ceil_div(cfg_k, TK, TK_SH);
            cfg_n_d   = cfg_n;
            cfg_k_d   = cfg_k;
            m_idx_d   = '0;
            n_idx_d   = '0;
            k_idx_d   = '0;
            rem_m_d   = cfg_m;
            rem_n_d   = cfg_n;
            rem_k_d   = cfg_k;
            first_k_d = 1'b1;
            last_k_d  = (cfg_k <= DIM_W'(TK));
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dp_ready) begin
          tile_start_s = 1'b1;
          state_d      = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dp_done) begin
          done_tile_d = last_k_q;
          if (final_s) begin
            // Indices hold on the final tile; they are reloaded on the next start.
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (!k_wrap_s) begin
              k_idx_d   = k_idx_q + {{(DIM_W-1){1'b0}}, 1'b1};
              rem_k_d   = rem_k_q - DIM_W'(TK);
              first_k_d = 1'b0;
              last_k_d  = ((k_idx_q + {{(DIM_W-2){1'b0}}, 2'd2}) == kt_q);
            end else begin
              k_idx_d   = '0;
              rem_k_d   = cfg_k_q;
              first_k_d = 1'b1;
              last_k_d  = (kt_q == {{(DIM_W-1){1'b0}}, 1'b1});
              if (!n_wrap_s) begin
                n_idx_d = n_idx_q + {{(DIM_W-1){1'b0}}, 1'b1};
                rem_n_d = rem_n_q - DIM_W'(TN);
              end else begin
                n_idx_d = '0;
                rem_n_d = cfg_n_q;
                m_idx_d = m_idx_q + {{(DIM_W-1){1'b0}}, 1'b1};
                rem_m_d = rem_m_q - DIM_W'(TM);
              end
            end
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lengths always track the remaining counts, so both update in the same cycle.
    m_len_d = LM_W'(clamp_len(rem_m_d, TM));
    n_len_d = LN_W'(clamp_len(rem_n_d, TN));
    k_len_d = LK_W'(clamp_len(rem_k_d, TK));
  end

  // State and tile-walk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mt_q        <= '0;
      nt_q        <= '0;
      kt_q        <= '0;
      cfg_n_q     <= '0;
      cfg_k_q     <= '0;
      m_idx_q     <= '0;
      n_idx_q     <= '0;
      k_idx_q     <= '0;
      rem_m_q     <= '0;
      rem_n_q     <= '0;
      rem_k_q     <= '0;
      m_len_q     <= '0;
      n_len_q     <= '0;
      k_len_q     <= '0;
      first_k_q   <= 1'b0;
      last_k_q    <= 1'b0;
      done_tile_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mt_q        <= mt_d;
      nt_q        <= nt_d;
      kt_q        <= kt_d;
      cfg_n_q     <= cfg_n_d;
      cfg_k_q     <= cfg_k_d;
      m_idx_q     <= m_idx_d;
      n_idx_q     <= n_idx_d;
      k_idx_q     <= k_idx_d;
      rem_m_q     <= rem_m_d;
      rem_n_q     <= rem_n_d;
      rem_k_q     <= rem_k_d;
      m_len_q     <= m_len_d;
      n_len_q     <= n_len_d;
      k_len_q     <= k_len_d;
      first_k_q   <= first_k_d;
      last_k_q    <= last_k_d;
      done_tile_q <= done_tile_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign tile_start = tile_start_s;
  assign tile_m_idx = m_idx_q;
  assign tile_n_idx = n_idx_q;
  assign tile_k_idx = k_idx_q;
  assign tile_m_len = m_len_q;
  assign tile_n_len = n_len_q;
  assign tile_k_len = k_len_q;
  assign first_k    = first_k_q;
  assign last_k     = last_k_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign done_tile  = done_tile_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_tile_sched.sv
// -----------------------------------------------------------------------------
// tb_tile_sched
// Self-checking bench for tile_sched (TM=TN=TK=8, DIM_W=16). A table of whole
// jobs is run against a small datapath model that answers each tile_start with
// dp_done three cycles later; hand-written sequences cover backpressure,
// ignored start, asynchronous reset mid-job and abort.
// Inputs change 1 time unit after the rising edge; outputs are read on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, dp_ready, dp_done;
  logic [15:0] cfg_m, cfg_n, cfg_k;
  logic        tile_start;
  logic [15:0] tile_m_idx, tile_n_idx, tile_k_idx;
  logic [3:0]  tile_m_len, tile_n_len, tile_k_len;
  logic        first_k, last_k, busy, done_tile, done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  tile_sched #(.TM(8), .TN(8), .TK(8), .DIM_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_m      (cfg_m),
    .cfg_n      (cfg_n),
    .cfg_k      (cfg_k),
    .dp_ready   (dp_ready),
    .dp_done    (dp_done),
    .tile_start (tile_start),
    .tile_m_idx (tile_m_idx),
    .tile_n_idx (tile_n_idx),
    .tile_k_idx (tile_k_idx),
    .tile_m_len (tile_m_len),
    .tile_n_len (tile_n_len),
    .tile_k_len (tile_k_len),
    .first_k    (first_k),
    .last_k     (last_k),
    .busy       (busy),
    .done_tile  (done_tile),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m, n, k;       // problem size
    int err;           // expect cfg_err
    int tiles;         // expected tile_start pulses
    int dtiles;        // expected done_tile pulses
    int lm, ln, lk;    // lengths of the final tile
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic st, input logic ab, input logic rdy, input logic dn);
    @(posedge clk);
    #1;
    start    = st;
    abort    = ab;
    dp_ready = rdy;
    dp_done  = dn;
    @(negedge clk);
  endtask

  function automatic int min8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic run_job(input vec_t v);
    int mt, nt, kt, em, en, ek;
    int ts_cnt, dt_cnt, dn_cnt, cyc, dd_cyc, last_dd, done_cyc, idle_cyc;
    int fin_m_len, fin_n_len, fin_k_len;
    mt = (v.m + 7) / 8;
    nt = (v.n + 7) / 8;
    kt = (v.k + 7) / 8;
    em = 0; en = 0; ek = 0;
    ts_cnt = 0; dt_cnt = 0; dn_cnt = 0;
    dd_cyc = -1; last_dd = -1; done_cyc = -1; idle_cyc = -1;
    fin_m_len = 0; fin_n_len = 0; fin_k_len = 0;
    cfg_m = 16'(v.m);
    cfg_n = 16'(v.n);
    cfg_k = 16'(v.k);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("job_c0_busy", busy, 0);
    cyc = 1;
    while (cyc < 70000 && idle_cyc < 0) begin
      step(1'b0, 1'b0, 1'b1, (cyc == dd_cyc));
      if (cyc == dd_cyc) last_dd = cyc;
      if (cyc == 1) begin
        chk("job_c1_cfg_err", cfg_err, v.err);
        chk("job_c1_busy", busy, (v.err == 0) ? 1 : 0);
        chk("job_c1_tile_start", tile_start, (v.err == 0) ? 1 : 0);
      end
      if (tile_start) begin
        chk("tile_m_idx", tile_m_idx, em);
        chk("tile_n_idx", tile_n_idx, en);
        chk("tile_k_idx", tile_k_idx, ek);
        chk("tile_m_len", tile_m_len, min8(v.m - em * 8));
        chk("tile_n_len", tile_n_len, min8(v.n - en * 8));
        chk("tile_k_len", tile_k_len, min8(v.k - ek * 8));
        chk("first_k", first_k, (ek == 0) ? 1 : 0);
        chk("last_k", last_k, (ek == kt - 1) ? 1 : 0);
        fin_m_len = tile_m_len; fin_n_len = tile_n_len; fin_k_len = tile_k_len;
        ek++;
        if (ek == kt) begin
          ek = 0;
          en++;
          if (en == nt) begin
            en = 0;
            em++;
          end
        end
        ts_cnt++;
        dd_cyc = cyc + 3;
      end
      if (done_tile) dt_cnt++;
      if (done) begin
        dn_cnt++;
        done_cyc = cyc;
      end
      if (!busy) idle_cyc = cyc;
      cyc++;
    end
    chk("job_terminated", (idle_cyc >= 0) ? 1 : 0, 1);
    chk("job_tile_starts", ts_cnt, v.tiles);
    chk("job_done_tiles", dt_cnt, v.dtiles);
    chk("job_done_pulses", dn_cnt, (v.err == 0) ? 1 : 0);
    if (v.err == 0) begin
      chk("job_model_tiles", ts_cnt, mt * nt * kt);
      chk("job_done_latency", done_cyc, last_dd + 1);
      chk("job_idle_latency", idle_cyc, last_dd + 2);
      chk("job_final_m_len", fin_m_len, v.lm);
      chk("job_final_n_len", fin_n_len, v.ln);
      chk("job_final_k_len", fin_k_len, v.lk);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{m: 16,  n: 16, k: 16,    err: 0, tiles: 8,    dtiles: 4, lm: 8, ln: 8, lk: 8};
    vecs[1] = '{m: 10,  n: 8,  k: 3,     err: 0, tiles: 2,    dtiles: 2, lm: 2, ln: 8, lk: 3};
    vecs[2] = '{m: 16,  n: 16, k: 0,     err: 1, tiles: 0,    dtiles: 0, lm: 0, ln: 0, lk: 0};
    vecs[3] = '{m: 1,   n: 1,  k: 1,     err: 0, tiles: 1,    dtiles: 1, lm: 1, ln: 1, lk: 1};
    vecs[4] = '{m: 17,  n: 9,  k: 20,    err: 0, tiles: 18,   dtiles: 6, lm: 1, ln: 1, lk: 4};
    vecs[5] = '{m: 0,   n: 5,  k: 5,     err: 1, tiles: 0,    dtiles: 0, lm: 0, ln: 0, lk: 0};
    vecs[6] = '{m: 8,   n: 8,  k: 8,     err: 0, tiles: 1,    dtiles: 1, lm: 8, ln: 8, lk: 8};
    vecs[7] = '{m: 1,   n: 1,  k: 65535, err: 0, tiles: 8192, dtiles: 1, lm: 1, ln: 1, lk: 7};

    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; dp_ready = 1'b0; dp_done = 1'b0;
    cfg_m = 16'd0; cfg_n = 16'd0; cfg_k = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tile_start", tile_start, 0);
    chk("rst_done", done, 0);
    chk("rst_done_tile", done_tile, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_m_idx", tile_m_idx, 0);
    chk("rst_k_len", tile_k_len, 0);
    chk("rst_first_last", {first_k, last_k}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i]);
    end

    // Backpressure, stray dp_done in ISSUE, ignored start, reset mid-WAIT.
    cfg_m = 16'd16; cfg_n = 16'd16; cfg_k = 16'd16;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 1'b0, 1'b0, (c == 3));
      chk("bp_no_tile_start", tile_start, 0);
      chk("bp_busy", busy, 1);
      chk("bp_k_idx", tile_k_idx, 0);
      chk("bp_m_len", tile_m_len, 8);
      chk("bp_k_len", tile_k_len, 8);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_release_tile_start", tile_start, 1);
    chk("bp_release_k_idx", tile_k_idx, 0);
    chk("bp_release_first_k", first_k, 1);
    chk("bp_release_last_k", last_k, 0);
    cfg_m = 16'd24; cfg_n = 16'd24; cfg_k = 16'd4;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("ign_wait_tile_start", tile_start, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ign_k_idx_before", tile_k_idx, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ign_tile_start", tile_start, 1);
    chk("ign_k_idx", tile_k_idx, 1);
    chk("ign_k_len", tile_k_len, 8);
    chk("ign_m_len", tile_m_len, 8);
    chk("ign_last_k", last_k, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_tile_start", tile_start, 0);
    chk("arst_k_idx", tile_k_idx, 0);
    chk("arst_k_len", tile_k_len, 0);
    chk("arst_last_k", last_k, 0);
    #1;
    rst_n = 1'b1;
    run_job(vecs[0]);

    // Abort together with dp_done during WAIT of the second tile.
    cfg_m = 16'd16; cfg_n = 16'd16; cfg_k = 16'd16;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ab_tile0_start", tile_start, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ab_tile1_start", tile_start, 1);
    chk("ab_tile1_k_idx", tile_k_idx, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ab_busy", busy, 0);
    chk("ab_done_tile", done_tile, 0);
    chk("ab_done", done, 0);
    chk("ab_tile_start", tile_start, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ab_done_late", done, 0);
    chk("ab_done_tile_late", done_tile, 0);
    run_job(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
